// File: rtl/grayscale_frame_ctrl_pkg.sv
// Shared definitions for the grayscale frame sequencer: FSM states and default frame geometry.
package grayscale_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int unsigned IMG_WIDTH_DEF  = 720;
  localparam int unsigned IMG_HEIGHT_DEF = 540;
  localparam int unsigned DP_LATENCY_DEF = 3;
  localparam int unsigned CNT_WIDTH_DEF  = 20;

endpackage

// File: rtl/grayscale_frame_ctrl_valid_pipe.sv
// Enabled valid shift register tracking occupancy of a fixed-latency datapath; dout is the head slot.
module valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] vld_q, vld_d;

  always_comb begin
    vld_d = vld_q;
    if (en) begin
      vld_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign dout = vld_q[DEPTH-1];

endmodule

// File: rtl/grayscale_frame_ctrl.sv
// Frame sequencer between input FIFO, conversion datapath and output FIFO.
// Optional stall/starve statistics outputs when GRAYSCALE_CTRL_STATS_EN is defined.
module grayscale_frame_ctrl
  import grayscale_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned DP_LATENCY = DP_LATENCY_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  input  logic                 fifo_in_empty,
  output logic                 fifo_in_rd_en,
  input  logic                 fifo_out_full,
  output logic                 fifo_out_wr_en,
  output logic                 dp_en,
  output logic                 dp_load,
  output logic [CNT_WIDTH-1:0] col,
  output logic [CNT_WIDTH-1:0] row
`ifdef GRAYSCALE_CTRL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] starve_cycles
`endif
);

  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] PIX_LAST = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] col_q, col_d, row_q, row_d, wr_cnt_q, wr_cnt_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 head, en, rd, wr, start_acc, last_rd, last_wr;

  // Only a valid head blocked by a full output FIFO freezes the pipe; bubbles keep flowing.
  assign en        = ~(head & fifo_out_full);
  assign rd        = (state_q == RUN) & ~fifo_in_empty & en;
  assign wr        = head & ~fifo_out_full;
  assign start_acc = (state_q == IDLE) & start;
  assign last_rd   = rd & (col_q == COL_LAST) & (row_q == ROW_LAST);
  assign last_wr   = wr & (wr_cnt_q == PIX_LAST);

  valid_pipe #(
    .DEPTH(DP_LATENCY)
  ) u_valid_pipe (
    .clock(clock),
    .reset(reset),
    .en   (en),
    .din  (rd),
    .dout (head)
  );

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    wr_cnt_d = wr_cnt_q;
    if (rd) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (wr) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          col_d    = '0;
          row_d    = '0;
          wr_cnt_d = '0;
        end
      end
      RUN:     if (last_rd) state_d = DRAIN;
      DRAIN:   if (last_wr) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      wr_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      wr_cnt_q <= wr_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign fifo_in_rd_en  = rd;
  assign dp_load        = rd;
  assign fifo_out_wr_en = wr;
  assign dp_en          = en;
  assign col            = col_q;
  assign row            = row_q;

`ifdef GRAYSCALE_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d, starve_q, starve_d;

  always_comb begin
    stall_d  = stall_q;
    starve_d = starve_q;
    if (start_acc) begin
      stall_d  = '0;
      starve_d = '0;
    end else begin
      if (busy_q && !en && (stall_q != '1)) begin
        stall_d = stall_q + 1'b1;
      end
      if ((state_q == RUN) && fifo_in_empty && en && (starve_q != '1)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign starve_cycles = starve_q;
`endif

endmodule

// File: tb/tb_grayscale_frame_ctrl.sv
// Randomized self-checking bench for grayscale_frame_ctrl (4x2 frame, latency 3) against a slot-level pixel model.
module tb_grayscale_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int L  = 3;
  localparam int CW = 20;
  localparam int N  = W * H;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic          fifo_in_empty;
  logic          fifo_in_rd_en;
  logic          fifo_out_full;
  logic          fifo_out_wr_en;
  logic          dp_en;
  logic          dp_load;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
`ifdef GRAYSCALE_CTRL_STATS_EN
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] starve_cycles;
`endif

  grayscale_frame_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DP_LATENCY(L),
    .CNT_WIDTH (CW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .frame_done    (frame_done),
    .fifo_in_empty (fifo_in_empty),
    .fifo_in_rd_en (fifo_in_rd_en),
    .fifo_out_full (fifo_out_full),
    .fifo_out_wr_en(fifo_out_wr_en),
    .dp_en         (dp_en),
    .dp_load       (dp_load),
    .col           (col),
    .row           (row)
`ifdef GRAYSCALE_CTRL_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .starve_cycles (starve_cycles)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pixel index per pipeline slot (-1 = bubble) and frame progress counts.
  int m_slot [L];
  bit m_active, m_done;
  int m_reads, m_writes, m_stall, m_starve;
  int avail;

  int cyc, o_rd, o_wr, first_rd, last_rd, first_wr, last_wr, done_cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < L; i++) m_slot[i] = -1;
    m_active = 0;
    m_done   = 0;
    m_reads  = 0;
    m_writes = 0;
    m_stall  = 0;
    m_starve = 0;
  endtask

  task automatic run_cycle(input bit st, input bit fe, input bit fo);
    bit emp, head, e_en, e_rd, e_wr;
    @(negedge clock);
    emp           = fe || (avail == 0);
    start         = st;
    fifo_in_empty = emp;
    fifo_out_full = fo;
    #1;
    head = (m_slot[L-1] >= 0);
    e_en = !(head && fo);
    e_rd = m_active && (m_reads < N) && !emp && e_en;
    e_wr = head && !fo;
    check_eq("busy", busy, m_active);
    check_eq("frame_done", frame_done, m_done);
    check_eq("dp_en", dp_en, e_en);
    check_eq("rd_en", fifo_in_rd_en, e_rd);
    check_eq("dp_load", dp_load, e_rd);
    check_eq("wr_en", fifo_out_wr_en, e_wr);
    check_eq("col", col, m_reads % W);
    check_eq("row", row, m_reads / W);
`ifdef GRAYSCALE_CTRL_STATS_EN
    check_eq("stall_cycles", stall_cycles, m_stall);
    check_eq("starve_cycles", starve_cycles, m_starve);
`endif
    cyc++;
    if (fifo_in_rd_en) begin
      if (o_rd == 0) first_rd = cyc;
      last_rd = cyc;
      o_rd++;
      if (avail > 0) avail--;
    end
    if (fifo_out_wr_en) begin
      if (o_wr == 0) first_wr = cyc;
      last_wr = cyc;
      o_wr++;
    end
    if (frame_done) done_cyc = cyc;
    if (m_active && !e_en) m_stall++;
    if (m_active && (m_reads < N) && emp && e_en) m_starve++;
    if (e_wr) m_writes++;
    if (e_en) begin
      for (int i = L - 1; i > 0; i--) m_slot[i] = m_slot[i-1];
      m_slot[0] = e_rd ? m_reads : -1;
    end
    if (e_rd) m_reads++;
    if (m_done) begin
      m_done = 0;
    end else if (m_active && e_wr && (m_writes == N)) begin
      m_active = 0;
      m_done   = 1;
    end else if (!m_active && st) begin
      m_active = 1;
      m_reads  = 0;
      m_writes = 0;
      m_stall  = 0;
      m_starve = 0;
    end
  endtask

  // mode: 0 free, 1 starve, 2 backpressure, 3 starve+backpressure, 4 random, 5 drain/restart
  task automatic do_frame(input int mode);
    int sl, bp;
    bit sdone, bdone, restarted, seen, fe, fo, st;
    sl = 0; bp = 0; sdone = 0; bdone = 0; restarted = 0; seen = 0;
    cyc = 0; o_rd = 0; o_wr = 0;
    first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
    run_cycle(1, 0, 0);
    for (int k = 0; k < 300 && !seen; k++) begin
      fe = 0; fo = 0; st = 0;
      if ((mode == 2 || mode == 3) && !bdone && (mode == 2 || sdone) && m_slot[L-1] >= 0) begin
        fo = 1;
        bp++;
        if (bp == 4) bdone = 1;
      end
      if ((mode == 1 || mode == 3) && !sdone && m_reads >= 2) begin
        fe = 1;
        sl++;
        if (sl == 5) sdone = 1;
      end
      if (mode == 4) begin
        fe = ($urandom_range(0, 3) == 0);
        fo = ($urandom_range(0, 3) == 0);
      end
      if (mode == 5 && !restarted && m_active && m_reads == N) begin
        st = 1;
        restarted = 1;
      end
      run_cycle(st, fe, fo);
      if (frame_done) seen = 1;
    end
    check_eq("frame_timeout", seen, 1);
    check_eq("frame_reads", o_rd, N);
    check_eq("frame_writes", o_wr, N);
    check_eq("done_after_last_wr", done_cyc - last_wr, 1);
    if (mode == 0) begin
      check_eq("read_burst_len", last_rd - first_rd, N - 1);
      check_eq("pixel_latency", first_wr - first_rd, L);
      check_eq("write_burst_len", last_wr - first_wr, N - 1);
    end
`ifdef GRAYSCALE_CTRL_STATS_EN
    if (mode == 3) begin
      check_eq("stats_stall", stall_cycles, 4);
      check_eq("stats_starve", starve_cycles, 5);
    end
`endif
    repeat (3) run_cycle(0, 0, 0);
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    fifo_in_empty = 1'b1;
    fifo_out_full = 1'b0;
    avail         = 0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_rd_en", fifo_in_rd_en, 0);
    check_eq("rst_wr_en", fifo_out_wr_en, 0);
    check_eq("rst_col", col, 0);
    check_eq("rst_row", row, 0);
    reset = 1'b1;

    avail = 100; do_frame(0);
    avail = 100; do_frame(1);
    avail = 100; do_frame(2);
    avail = 100; do_frame(3);

    avail = 12;
    do_frame(5);
    check_eq("words_left", avail, 4);

    avail = 100;
    run_cycle(1, 0, 0);
    for (int k = 0; k < 50 && m_reads < 5; k++) run_cycle(0, 0, 0);
    check_eq("reads_before_reset", m_reads, 5);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_frame_done", frame_done, 0);
    check_eq("mid_rst_rd_en", fifo_in_rd_en, 0);
    check_eq("mid_rst_wr_en", fifo_out_wr_en, 0);
    check_eq("mid_rst_col", col, 0);
    check_eq("mid_rst_row", row, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    avail = 100; do_frame(0);

    for (int f = 0; f < 4; f++) begin
      avail = 100;
      do_frame(4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/grayscale_frame_ctrl.md
# grayscale_frame_ctrl

Frame sequencer for the grayscale pipeline inside `dut_system`. It sits between the input pixel FIFO (24-bit RGB, first-word-fall-through) and the output FIFO. It paces reads, drives the stall enable of the fixed-latency conversion datapath, and tracks in-flight pixels. It counts one frame of `IMG_WIDTH*IMG_HEIGHT` pixels in and out, then reports completion.

## Interface
- `IMG_WIDTH`, 720, pixels per row
- `IMG_HEIGHT`, 540, rows per frame
- `DP_LATENCY`, 3, datapath pipeline depth in enabled cycles (≥1)
- `CNT_WIDTH`, 20, width of pixel counters (must hold `IMG_WIDTH*IMG_HEIGHT`)
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; begins a frame when idle
- `busy`  out  1  high from accepted `start` until `frame_done`
- `frame_done`  out  1  one-cycle pulse when the last pixel is written
- `fifo_in_empty`  in  1  input FIFO empty
- `fifo_in_rd_en`  out  1  input FIFO pop (FWFT: data consumed same cycle)
- `fifo_out_full`  in  1  output FIFO full
- `fifo_out_wr_en`  out  1  output FIFO push
- `dp_en`  out  1  datapath stage enable (global stall when low)
- `dp_load`  out  1  datapath stage-0 captures `fifo_in_dout` this cycle
- `col`  out  `CNT_WIDTH`  column of the next pixel read
- `row`  out  `CNT_WIDTH`  row of the next pixel read

## Operation
- FSM states:
  - IDLE: `start` → RUN.
  - RUN: last read issued → DRAIN.
  - DRAIN: last write issued → DONE.
  - DONE: one cycle, then → IDLE.
- `start` outside IDLE is ignored.
- `dp_en` = ~(vld[DP_LATENCY-1] & `fifo_out_full`). The whole pipeline freezes only when its head cannot be written.
- `fifo_in_rd_en` = `dp_load` = RUN & ~`fifo_in_empty` & `dp_en`.
- The valid shift register vld[0..DP_LATENCY-1] advances only when `dp_en`=1. vld[0] takes `dp_load`.
- `fifo_out_wr_en` = vld[DP_LATENCY-1] & ~`fifo_out_full`.
- Read counters:
  - `col` increments on each read and wraps to 0 at `IMG_WIDTH-1`.
  - On that wrap, `row` increments.
  - The read with `col`=`IMG_WIDTH-1` and `row`=`IMG_HEIGHT-1` is the last read.
- Write counter: counts writes; its terminal value `IMG_WIDTH*IMG_HEIGHT-1` marks the last write.
- All counters clear on `start` acceptance.
- In DRAIN no further reads are issued, even if `fifo_in_empty`=0. Excess input data stays in the FIFO for the next frame.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0.
  - `col`=`row`=0.
  - vld all 0.
- `busy` is registered: it rises the cycle after `start` and falls in the same cycle `frame_done` is high.
- `frame_done` is registered and asserts one cycle after the last write.
- Pixel latency with no stalls: a read at cycle t produces a write at cycle t+`DP_LATENCY`.
- Throughput is one pixel per cycle with no stalls.
- Input empty during RUN: a bubble enters the pipeline. Writes already in flight continue.
- `fifo_out_full` while vld[DP_LATENCY-1]=1:
  - No write and no read.
  - All state is held.
  - Resumes on the first cycle full drops.
- `fifo_out_full` with vld[DP_LATENCY-1]=0: no stall. Bubbles collapse.
- Simultaneous read and write in one cycle: both occur.
- Reset mid-frame: everything clears immediately. In-flight pixels are lost. The FIFOs are reset externally.
- With `IMG_WIDTH`=`IMG_HEIGHT`=1: RUN lasts a single read, and `frame_done` asserts at `start`+`DP_LATENCY`+2.

## Configuration
- `GRAYSCALE_CTRL_STATS_EN` defined: adds outputs `stall_cycles` and `starve_cycles` (`CNT_WIDTH` each), cleared on `start` and saturating.
  - `stall_cycles` counts busy cycles with `dp_en`=0.
  - `starve_cycles` counts RUN cycles with `fifo_in_empty`=1 and `dp_en`=1.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- `grayscale_pkg`: FSM state enum (IDLE/RUN/DRAIN/DONE) and default frame-size and latency constants. `dut_system` and the testbench share the frame-size constants.
- One sub-module, `valid_pipe`: the `DP_LATENCY`-deep valid shift register with enable. It is reusable by other fixed-latency stages.

## Test plan
Bench configuration for all scenarios unless noted: `IMG_WIDTH`=4, `IMG_HEIGHT`=2, `DP_LATENCY`=3.
- Free-flowing:
  - Stimulus: input never empty, output never full.
  - Expected: 8 reads in consecutive cycles, then 8 writes with the first at read+3, and `frame_done` 1 cycle after the 8th write.
  - Check `row`/`col` sequence (0,0)…(1,3).
- Input starvation:
  - Stimulus: `fifo_in_empty`=1 for 5 cycles after read 2.
  - Expected: bubbles propagate, write count is still 8, and no write occurs in bubble slots.
- Output backpressure:
  - Stimulus: `fifo_out_full`=1 for 4 cycles once vld head is set.
  - Expected: `dp_en`=0 for those 4 cycles, `fifo_in_rd_en`=0, counters frozen, no data lost.
- Drain and start ignore:
  - Stimulus: 12 words available in the input FIFO; `start` re-pulsed in DRAIN.
  - Expected: exactly 8 reads, the `start` is ignored, and 4 words remain.
- Reset mid-frame:
  - Stimulus: reset after 5 reads.
  - Expected: outputs 0 and state IDLE. A new `start` yields a clean 8-pixel frame.
- Stats, with `GRAYSCALE_CTRL_STATS_EN` defined:
  - Stimulus: the backpressure and starvation scenarios combined.
  - Expected: `stall_cycles`=4, `starve_cycles`=5.
